// File: rtl/dmg_timer.sv
// DMG divider/timer (DIV, TIMA, TMA, TAC) with falling-edge TIMA clocking,
// write-induced glitch increments and the delayed overflow reload.
module dmg_timer #(
   parameter int OVF_DELAY = 4
) (
   input  logic       clk,
   input  logic       res,
   input  logic       ce,
   input  logic       cs,
   input  logic       wr,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq_req
);

   // state  | meaning
   // RUN    | TIMA counts falling edges of the selected divider tap
   // OVF    | TIMA reads 00, counting down dly before the TMA reload
   // RELOAD | one ce-cycle after reload; TIMA writes ignored, TMA writes mirror into TIMA
   typedef enum logic [1:0] {RUN, OVF, RELOAD} state_t;

   state_t      state;
   logic [15:0] div_cnt;
   logic [7:0]  tima;
   logic [7:0]  tma;
   logic [2:0]  tac;
   logic [3:0]  dly;
   logic        sig_prev;

   logic        tap_bit;
   logic        sig;
   logic        fall;
   logic        wr_div;
   logic        wr_tima;
   logic        wr_tma;
   logic        wr_tac;

   always_comb begin
      tap_bit = 1'b0;
      case (tac[1:0])
         2'b00: tap_bit = div_cnt[9];
         2'b01: tap_bit = div_cnt[3];
         2'b10: tap_bit = div_cnt[5];
         2'b11: tap_bit = div_cnt[7];
         default: tap_bit = 1'b0;
      endcase
   end

   // Sampling the gated tap from registers is what makes DIV/TAC writes glitch.
   assign sig  = tac[2] & tap_bit;
   assign fall = sig_prev & ~sig;

   assign wr_div  = cs & wr & (addr == 2'd0);
   assign wr_tima = cs & wr & (addr == 2'd1);
   assign wr_tma  = cs & wr & (addr == 2'd2);
   assign wr_tac  = cs & wr & (addr == 2'd3);

   always_comb begin
      dout = 8'h00;
      case (addr)
         2'd0: dout = div_cnt[15:8];
         2'd1: dout = tima;
         2'd2: dout = tma;
         2'd3: dout = {5'b11111, tac};
         default: dout = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         div_cnt  <= 16'h0000;
         tima     <= 8'h00;
         tma      <= 8'h00;
         tac      <= 3'b000;
         sig_prev <= 1'b0;
         state    <= RUN;
         dly      <= 4'd0;
         irq_req  <= 1'b0;
      end else begin
         // The request is a single clk pulse even when ce is sparse.
         irq_req <= 1'b0;
         if (ce) begin
            div_cnt  <= wr_div ? 16'h0000 : div_cnt + 16'd1;
            sig_prev <= sig;
            if (wr_tma) tma <= din;
            if (wr_tac) tac <= din[2:0];
            case (state)
               RUN: begin
                  if (wr_tima) begin
                     tima <= din;
                  end else if (fall) begin
                     if (tima == 8'hFF) begin
                        tima  <= 8'h00;
                        dly   <= 4'(OVF_DELAY - 1);
                        state <= OVF;
                     end else begin
                        tima <= tima + 8'd1;
                     end
                  end
               end
               OVF: begin
                  if (wr_tima) begin
                     tima  <= din;
                     dly   <= 4'd0;
                     state <= RUN;
                  end else if (dly != 4'd0) begin
                     dly <= dly - 4'd1;
                  end else begin
                     tima    <= wr_tma ? din : tma;
                     irq_req <= 1'b1;
                     state   <= RELOAD;
                  end
               end
               RELOAD: begin
                  if (wr_tma) tima <= din;
                  state <= RUN;
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmg_timer.sv
// Self-checking bench for dmg_timer: register vector table plus hand-built
// sequences for edge, glitch, overflow and reload corner cases.
module tb_dmg_timer;

   logic       clk = 1'b0;
   logic       res, ce, cs, wr;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       irq_req;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       r, c, s, w;
      logic [1:0] a;
      logic [7:0] d;
      logic [7:0] exp_dout;
      logic       exp_irq;
   } vec_t;

   typedef struct {
      string      name;
      logic [7:0] dout;
      logic       irq;
   } exp_t;

   vec_t tbl[18];
   exp_t sbq[$];

   dmg_timer #(.OVF_DELAY(4)) dut (
      .clk(clk), .res(res), .ce(ce), .cs(cs), .wr(wr),
      .addr(addr), .din(din), .dout(dout), .irq_req(irq_req)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic step(input logic r, input logic c, input logic s, input logic w,
                       input logic [1:0] a, input logic [7:0] d, input bit chk,
                       input logic [7:0] ed, input logic ei, input string nm);
      exp_t e;
      @(negedge clk);
      res = r; ce = c; cs = s; wr = w; addr = a; din = d;
      if (chk) sbq.push_back('{nm, ed, ei});
      @(posedge clk);
      #1;
      if (chk) begin
         e = sbq.pop_front();
         n_vec++;
         if (dout !== e.dout || irq_req !== e.irq) begin
            n_err++;
            $display("FAIL %s: got dout=%02h irq=%0b, expected dout=%02h irq=%0b",
                     e.name, dout, irq_req, e.dout, e.irq);
         end
      end
   endtask

   task automatic idle(input int n, input logic [1:0] a);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0, "");
   endtask

   task automatic chk(input logic [1:0] a, input logic [7:0] ed, input logic ei, input string nm);
      step(1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00, 1'b1, ed, ei, nm);
   endtask

   task automatic wreg(input logic [1:0] a, input logic [7:0] d);
      step(1'b0, 1'b1, 1'b1, 1'b1, a, d, 1'b0, 8'h00, 1'b0, "");
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, "");
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, "");
   endtask

   // Leaves the bench at ce-cycle 16 after reset; cycle 17 is the overflowing edge.
   task automatic setup_ovf();
      do_reset();
      wreg(2'd2, 8'hAB);
      wreg(2'd3, 8'h05);
      wreg(2'd1, 8'hFF);
      idle(13, 2'd1);
   endtask

   function automatic logic [7:0] toggle_tima(input int k);
      if (k < 17) return 8'hFF;
      if (k < 21) return 8'h00;
      return 8'hAB;
   endfunction

   initial begin
      res = 1'b1; ce = 1'b0; cs = 1'b0; wr = 1'b0; addr = 2'd0; din = 8'h00;

      //           r     c     s     w     a      d      dout   irq
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 8'hF8, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h3C, 8'h3C, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h12, 8'h12, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'hFC, 8'hFC, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'hF8, 8'hF8, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h99, 8'h12, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'h77, 8'h3C, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h55, 8'h3C, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'hA5, 8'h00, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 8'h66, 8'h00, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 8'hF8, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'h07, 8'hFF, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 8'hF8, 1'b0};

      for (int i = 0; i < 18; i++)
         step(tbl[i].r, tbl[i].c, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d,
              1'b1, tbl[i].exp_dout, tbl[i].exp_irq, $sformatf("table[%0d]", i));

      // DIV upper byte ticks after 256 ce-cycles
      do_reset();
      idle(254, 2'd0);
      chk(2'd0, 8'h00, 1'b0, "div_255");
      chk(2'd0, 8'h01, 1'b0, "div_256");

      // bit-3 tap: edges land on ce-cycles 17, 33, ...
      do_reset();
      wreg(2'd3, 8'h05);
      idle(14, 2'd1);
      chk(2'd1, 8'h00, 1'b0, "rate_before_edge");
      chk(2'd1, 8'h01, 1'b0, "rate_first_edge");
      idle(238, 2'd1);
      chk(2'd1, 8'h0F, 1'b0, "rate_c256");
      chk(2'd1, 8'h10, 1'b0, "rate_c257");

      // overflow and reload
      setup_ovf();
      chk(2'd1, 8'h00, 1'b0, "ovf_c17");
      chk(2'd1, 8'h00, 1'b0, "ovf_c18");
      chk(2'd1, 8'h00, 1'b0, "ovf_c19");
      chk(2'd1, 8'h00, 1'b0, "ovf_c20");
      chk(2'd1, 8'hAB, 1'b1, "ovf_reload");
      chk(2'd1, 8'hAB, 1'b0, "ovf_irq_clear");
      chk(2'd1, 8'hAB, 1'b0, "ovf_after");

      // TIMA write during OVF cancels reload
      setup_ovf();
      chk(2'd1, 8'h00, 1'b0, "cancel_c17");
      chk(2'd1, 8'h00, 1'b0, "cancel_c18");
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h55, 1'b1, 8'h55, 1'b0, "cancel_write");
      for (int k = 20; k <= 32; k++) chk(2'd1, 8'h55, 1'b0, $sformatf("cancel_hold_c%0d", k));
      chk(2'd1, 8'h56, 1'b0, "cancel_next_edge");

      // DIV write while bit 9 high
      do_reset();
      wreg(2'd3, 8'h04);
      idle(16'h2FE, 2'd1);
      chk(2'd1, 8'h00, 1'b0, "divglitch_pre");
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'h5A, 1'b1, 8'h00, 1'b0, "divglitch_divread");
      chk(2'd1, 8'h01, 1'b0, "divglitch_inc");

      // TAC disable while bit 3 high
      do_reset();
      wreg(2'd3, 8'h05);
      idle(6, 2'd1);
      chk(2'd1, 8'h00, 1'b0, "tacglitch_pre");
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 8'h00, 1'b1, 8'hF8, 1'b0, "tacglitch_write");
      chk(2'd1, 8'h01, 1'b0, "tacglitch_inc");
      idle(19, 2'd1);
      chk(2'd1, 8'h01, 1'b0, "tacglitch_stopped");

      // TMA write in RELOAD mirrors into TIMA
      setup_ovf();
      idle(4, 2'd1);
      chk(2'd1, 8'hAB, 1'b1, "rl_tma_reload");
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h22, 1'b1, 8'h22, 1'b0, "rl_tma_write");
      chk(2'd1, 8'h22, 1'b0, "rl_tma_tima");

      // TIMA write in RELOAD is ignored
      setup_ovf();
      idle(4, 2'd1);
      chk(2'd1, 8'hAB, 1'b1, "rl_tima_reload");
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h77, 1'b1, 8'hAB, 1'b0, "rl_tima_ignored");
      chk(2'd1, 8'hAB, 1'b0, "rl_tima_hold");

      // TMA write on the OVF->RELOAD cycle loads the new data
      setup_ovf();
      idle(4, 2'd1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hC4, 1'b1, 8'hC4, 1'b1, "same_cycle_tma");
      chk(2'd1, 8'hC4, 1'b0, "same_cycle_tima");

      // sparse ce: irq still one clk wide
      do_reset();
      wreg(2'd2, 8'hAB);
      wreg(2'd3, 8'h05);
      wreg(2'd1, 8'hFF);
      for (int k = 4; k <= 24; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1, toggle_tima(k), (k == 21) ? 1'b1 : 1'b0,
              $sformatf("ce_toggle_on_c%0d", k));
         step(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1, toggle_tima(k), 1'b0,
              $sformatf("ce_toggle_off_c%0d", k));
      end

      // reset mid-overflow
      setup_ovf();
      idle(2, 2'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, "rst_ovf_0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, "rst_ovf_1");
      for (int k = 0; k < 8; k++) chk(2'd1, 8'h00, 1'b0, $sformatf("rst_ovf_after_%0d", k));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
